// File: rtl/transmit_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transmit_buffer_pkg
// Description : Shared types and helpers for the UART transmit byte buffer:
//               transmit FSM state encoding, pointer width, pointer wrap.
// Revision    : 1.0 - initial release
// ============================================================================
package transmit_buffer_pkg;

  // Pointer width is fixed so any depth up to 65535 fits without rework.
  localparam int PTR_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_e;

  // Explicit wrap at the last slot; depth is not assumed to be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                input logic [PTR_W-1:0] last);
    return (ptr == last) ? '0 : ptr + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/transmit_buffer_ring_ram.sv
`default_nettype none
// ============================================================================
// Module      : tx_ring_ram
// Description : Byte array for the transmit ring buffer. Synchronous write
//               port, asynchronous read port (the caller registers the data).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_ring_ram #(
  parameter int DEPTH = 2000,
  parameter int AW    = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port: contents are never reset, only the pointers are.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No write-to-read bypass: a byte written this edge is readable next cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/transmit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : transmit_buffer
// Description : Circular byte buffer feeding a UART transmitter. Pushes from
//               the SoC side are dropped (never overwrite) when full, with a
//               sticky overflow flag. A four-state FSM pops one byte at a time
//               and hands it over with a start pulse / busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module transmit_buffer
  import transmit_buffer_pkg::*;
#(
  parameter logic EN_RESET = 1'b1,
  parameter int   MAX_SIZE = 2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [7:0]  wr_data_i,
  input  logic        tx_busy_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [15:0] count_o,
  output logic        overflow_o
);

  localparam int               AW       = $clog2(MAX_SIZE);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_SIZE - 1);
  localparam logic [15:0]      FULL_CNT = 16'(MAX_SIZE);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       tx_data_q, tx_data_d;
  tx_state_e        state_q, state_d;

  logic             w_push_ok;
  logic             w_pop;
  logic [7:0]       w_ram_rdata;

  tx_ring_ram #(
    .DEPTH (MAX_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_push_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (w_ram_rdata)
  );

  // Flags come straight from the occupancy register; full is judged before
  // any same-cycle pop, so a push while full is dropped even if a pop occurs.
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == 16'd0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign tx_data_o  = tx_data_q;

  assign w_push_ok  = wr_en_i & ~full_o;
  assign w_pop      = (state_q == TX_IDLE) & ~empty_o & ~tx_busy_i;

  // Next-state for pointers, occupancy, sticky overflow and the output byte.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;

    if (w_push_ok) begin
      wr_ptr_d = ptr_next(wr_ptr_q, LAST_PTR);
    end
    if (wr_en_i && full_o) begin
      overflow_d = 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d  = ptr_next(rd_ptr_q, LAST_PTR);
      tx_data_d = w_ram_rdata;
    end

    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + 16'd1;
      2'b01:   count_d = count_q - 16'd1;
      default: count_d = count_q;
    endcase
  end

  // Datapath registers; reset discards any queued bytes.
  always_ff @(posedge clk_i) begin
    if (rst_i == EN_RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Transmit FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i == EN_RESET) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transmit FSM next-state and Moore start pulse.
  always_comb begin
    state_d    = state_q;
    tx_start_o = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (w_pop) begin
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_start_o = 1'b1;
        state_d    = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = TX_WAIT_DONE;
        end
      end
      TX_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_transmit_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_transmit_buffer
// Description : Self-checking bench for transmit_buffer (depth 4). Expected
//               bytes are queued when pushed and compared at each start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transmit_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        full;
  logic        empty;
  logic [15:0] count;
  logic        overflow;

  logic        model_busy;
  logic        hold_busy;
  logic        man_busy;
  logic        model_en;
  logic        model_active;
  int          busy_delay;
  int          busy_len;

  int          checks;
  int          errors;
  int          starts;
  logic [7:0]  sb[$];
  event        start_ev;

  assign tx_busy = model_busy | hold_busy | man_busy;

  transmit_buffer #(
    .EN_RESET (1'b1),
    .MAX_SIZE (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter-side monitor: every start pulse consumes one expected byte.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL start_unexpected: got start with data %02h, required no start", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_data_order: got %02h, required %02h", tx_data, exp_b);
          end
        end
        -> start_ev;
      end
    end
  end

  // Transmitter busy model: raise busy a few cycles after start, hold it.
  initial begin
    model_busy   = 1'b0;
    model_active = 1'b0;
    forever begin
      @(start_ev);
      if (model_en) begin
        model_active = 1'b1;
        repeat (busy_delay) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 model_busy = 1'b0;
        model_active = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) sb.push_back(b);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (count == 16'd0 && tx_busy == 1'b0 && sb.size() == 0 && !model_active) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain_timeout: count %0d queue %0d, required 0 0", name, count, sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    checks += 6;
    if (count !== 16'd0)   begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
    if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
    if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b, required 0", full); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b, required 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", tx_data); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_single_byte();
    int s0;
    s0 = starts;
    busy_delay = 2;
    busy_len   = 10;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    sb.push_back(8'hA5);
    @(posedge clk);            // edge N
    #1 wr_en = 1'b0;
    @(negedge clk);
    checks += 2;
    if (count !== 16'd1)   begin errors++; $display("FAIL single_count_after_push: got %0d, required 1", count); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b, required 0", tx_start); end
    @(posedge clk);            // edge N+1: pop
    @(negedge clk);
    checks += 3;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b, required 1", tx_start); end
    if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h, required a5", tx_data); end
    if (count !== 16'd0)   begin errors++; $display("FAIL single_count_after_pop: got %0d, required 0", count); end
    @(posedge clk);
    #1;
    wait_drain("single");
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL single_start_count: got %0d, required 1", starts - s0); end
  endtask

  task automatic test_burst();
    int s0;
    s0 = starts;
    busy_delay = 2;
    busy_len   = 8;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    wait_drain("burst");
    checks++;
    if (starts - s0 != 5) begin errors++; $display("FAIL burst_start_count: got %0d, required 5", starts - s0); end
  endtask

  task automatic test_full_overflow();
    int s0;
    s0 = starts;
    hold_busy = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
    checks += 4;
    if (full !== 1'b1)     begin errors++; $display("FAIL full_flag: got %b, required 1", full); end
    if (count !== 16'd4)   begin errors++; $display("FAIL full_count: got %0d, required 4", count); end
    if (empty !== 1'b0)    begin errors++; $display("FAIL full_empty: got %b, required 0", empty); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_early: got %b, required 0", overflow); end
    push(8'hEE, 1'b0);
    push(8'hEF, 1'b0);
    checks += 2;
    if (count !== 16'd4)   begin errors++; $display("FAIL overflow_count: got %0d, required 4", count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", overflow); end
    repeat (3) @(posedge clk);
    #1 hold_busy = 1'b0;
    wait_drain("full");
    checks += 2;
    if (starts - s0 != 4)  begin errors++; $display("FAIL full_start_count: got %0d, required 4", starts - s0); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b, required 1", overflow); end
  endtask

  // Hand-driven transmitter so every later push lands on a pop edge.
  task automatic test_wrap_simultaneous();
    int s0;
    logic [15:0] prev;
    s0 = starts;
    model_en = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h10;
    sb.push_back(8'h10);
    @(posedge clk);            // push 0x10
    #1 wr_data = 8'h11;
    sb.push_back(8'h11);
    prev = count;
    @(posedge clk);            // pop 0x10 + push 0x11
    #1 wr_en = 1'b0;
    @(negedge clk);
    checks += 2;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL wrap_pop_first: got %b, required 1", tx_start); end
    if (count !== prev)    begin errors++; $display("FAIL wrap_count_first: got %0d, required %0d", count, prev); end
    for (int k = 2; k < 10; k++) begin
      @(posedge clk); #1 man_busy = 1'b1;
      @(posedge clk); #1 man_busy = 1'b0;
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(k);
      sb.push_back(8'h10 + 8'(k));
      prev = count;
      @(posedge clk);
      #1 wr_en = 1'b0;
      @(negedge clk);
      checks += 2;
      if (tx_start !== 1'b1) begin errors++; $display("FAIL wrap_pop_%0d: got %b, required 1", k, tx_start); end
      if (count !== prev)    begin errors++; $display("FAIL wrap_count_%0d: got %0d, required %0d", k, count, prev); end
    end
    @(posedge clk); #1 man_busy = 1'b1;
    @(posedge clk); #1 man_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL wrap_last_pop: got %b, required 1", tx_start); end
    @(posedge clk); #1 man_busy = 1'b1;
    @(posedge clk); #1 man_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (count !== 16'd0)   begin errors++; $display("FAIL wrap_final_count: got %0d, required 0", count); end
    if (sb.size() != 0)    begin errors++; $display("FAIL wrap_queue_left: got %0d, required 0", sb.size()); end
    if (starts - s0 != 10) begin errors++; $display("FAIL wrap_start_count: got %0d, required 10", starts - s0); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    bit seen;
    busy_delay = 2;
    busy_len   = 10;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i), 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx_busy) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_busy_timeout: got busy %b, required 1", tx_busy); end
    repeat (2) @(posedge clk);  // FSM now waiting for the frame to finish
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    checks += 4;
    if (count !== 16'd0)   begin errors++; $display("FAIL midrst_count: got %0d, required 0", count); end
    if (empty !== 1'b1)    begin errors++; $display("FAIL midrst_empty: got %b, required 1", empty); end
    if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b, required 0", tx_start); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h, required 00", tx_data); end
    s0 = starts;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (starts != s0) begin errors++; $display("FAIL midrst_no_start: got %0d starts, required 0", starts - s0); end
    push(8'h77, 1'b1);
    wait_drain("midrst");
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL midrst_new_start: got %0d, required 1", starts - s0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    starts     = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    hold_busy  = 1'b0;
    man_busy   = 1'b0;
    model_en   = 1'b1;
    busy_delay = 2;
    busy_len   = 10;

    test_reset();
    test_single_byte();
    test_burst();
    test_full_overflow();
    test_reset();
    test_wrap_simultaneous();
    test_reset_mid_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
